// File: rtl/led_pattern_sequencer_if.sv
// AXI4-Lite write-channel bundle between the
// pattern sequencer and the LED controller.
interface led_pattern_sequencer_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Free-running LED pattern generator that writes each
// new pattern to the LED controller over AXI4-Lite.
module led_pattern_sequencer #(
  parameter int unsigned LED_WIDTH  = 4,
  parameter int unsigned PERIOD     = 1000,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] REG_OFFSET = 32'h0
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 err_clr,
  output logic [LED_WIDTH-1:0] led_value,
  output logic                 busy,
  output logic                 err,
  output logic                 overrun,
  led_pattern_sequencer_if.master m_axi
);

  localparam int unsigned CW = $clog2(PERIOD);

  typedef enum logic [1:0] {
    IDLE, WAIT, XFER, RESP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 pending;
  logic [LED_WIDTH-1:0] wdata_q;
  logic [LED_WIDTH-1:0] next_val;
  logic                 tick;
  logic                 aw_ok;
  logic                 w_ok;
  logic                 b_hs;
  logic                 in_flight;

  assign tick  = enable && (cnt == CW'(PERIOD - 1));
  assign aw_ok = !m_axi.awvalid || m_axi.awready;
  assign w_ok  = !m_axi.wvalid || m_axi.wready;
  assign b_hs  = m_axi.bvalid && m_axi.bready;
  assign in_flight = (state == XFER) || (state == RESP);

  assign m_axi.awaddr = BASE_ADDR + REG_OFFSET;
  assign m_axi.awprot = 3'b000;
  assign m_axi.wstrb  = 4'hF;
  assign m_axi.wdata  = 32'(wdata_q);

  always_comb begin
    next_val = led_value;
    unique case (1'b1)
      mode == 2'd0:
        next_val = led_value + LED_WIDTH'(1);
      mode == 2'd1:
        next_val = (led_value == '0)
          ? LED_WIDTH'(1)
          : (led_value << 1)
            | (led_value >> (LED_WIDTH - 1));
      mode == 2'd2:
        next_val = ~led_value;
      default:
        next_val = led_value;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      pending       <= 1'b0;
      wdata_q       <= '0;
      led_value     <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      overrun       <= 1'b0;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
    end else begin
      if (err_clr) begin
        err     <= 1'b0;
        overrun <= 1'b0;
      end
      // only one tick may wait behind a write
      if (tick && in_flight) begin
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (enable) state <= WAIT;
        end
        WAIT: begin
          if (!enable) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else if (tick || pending) begin
            wdata_q       <= next_val;
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            busy          <= 1'b1;
            pending       <= 1'b0;
            state         <= XFER;
          end
        end
        XFER: begin
          if (m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wready) m_axi.wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi.bready <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            m_axi.bready <= 1'b0;
            busy         <= 1'b0;
            if (m_axi.bresp == 2'b00) begin
              led_value <= wdata_q;
            end else begin
              err <= 1'b1;
            end
            if (enable) begin
              state <= WAIT;
            end else begin
              state   <= IDLE;
              pending <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised and directed bench for the LED pattern
// sequencer against a transaction-level model.
module tb_led_pattern_sequencer;

  localparam int P = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] OFF  = 32'h0000_0010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       err_clr = 1'b0;
  logic [3:0] led_value;
  logic       busy, err, overrun;

  led_pattern_sequencer_if bus();

  led_pattern_sequencer #(
    .LED_WIDTH(4), .PERIOD(P),
    .BASE_ADDR(BASE), .REG_OFFSET(OFF)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .enable(enable), .mode(mode),
    .err_clr(err_clr), .led_value(led_value),
    .busy(busy), .err(err), .overrun(overrun),
    .m_axi(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  int m_phase, m_led, m_wd;
  bit m_pend, m_act, m_aw, m_w, m_b, m_err, m_ovr;
  // inputs seen during the cycle before an edge
  bit s_rst, s_en, s_clr, s_awr, s_wr, s_bv;
  int s_mode, s_bresp;
  bit d_awv, d_wv, d_br;
  logic [31:0] d_wd;
  // slave
  bit sl_aw, sl_w, sl_bp, saw_w_only;
  int sl_cnt, sl_lag, sl_resp;
  int aw_pct, w_pct, w_lag, bdel_min, bdel_max;
  int err_idx, err_pct;
  int wr_issued, b_count;
  int wq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int next_of(int led, int md);
    case (md)
      0: return (led + 1) % 16;
      1: return (led == 0) ? 1
                : ((led * 2) % 16) + (led / 8);
      2: return 15 - led;
      default: return led;
    endcase
  endfunction

  task automatic model_step();
    bit tick, set_err, set_ovr;
    if (!s_rst) begin
      m_phase = 0; m_led = 0; m_wd = 0;
      m_pend = 0; m_act = 0; m_aw = 0;
      m_w = 0; m_b = 0; m_err = 0; m_ovr = 0;
      return;
    end
    tick = s_en && (m_phase == P - 1);
    m_phase = s_en ? (m_phase + 1) % P : 0;
    set_err = 0;
    set_ovr = 0;
    if (m_act) begin
      if (tick) begin
        if (m_pend) set_ovr = 1;
        m_pend = 1;
      end
      if (m_b) begin
        if (s_bv) begin
          m_b = 0;
          m_act = 0;
          if (s_bresp == 0) m_led = m_wd;
          else set_err = 1;
          if (!s_en) m_pend = 0;
        end
      end else begin
        if (m_aw && s_awr) m_aw = 0;
        if (m_w && s_wr) m_w = 0;
        if (!m_aw && !m_w) m_b = 1;
      end
    end else if (!s_en) begin
      m_pend = 0;
    end else if (tick || m_pend) begin
      m_wd = next_of(m_led, s_mode);
      m_aw = 1;
      m_w = 1;
      m_act = 1;
      m_pend = 0;
    end
    m_err = (m_err && !s_clr) || set_err;
    m_ovr = (m_ovr && !s_clr) || set_ovr;
  endtask

  task automatic compare();
    chk("led_value", 32'(led_value), m_led);
    chk("busy", 32'(busy), 32'(m_act));
    chk("err", 32'(err), 32'(m_err));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("awvalid", 32'(bus.awvalid), 32'(m_aw));
    chk("wvalid", 32'(bus.wvalid), 32'(m_w));
    chk("bready", 32'(bus.bready), 32'(m_b));
    if (m_aw) begin
      chk("awaddr", bus.awaddr, BASE + OFF);
      chk("awprot", 32'(bus.awprot), 0);
    end
    if (m_w) begin
      chk("wdata", bus.wdata, m_wd);
      chk("wstrb", 32'(bus.wstrb), 32'hF);
    end
  endtask

  task automatic slave_drive();
    if (!s_rst || !rst_n) begin
      sl_aw = 0; sl_w = 0; sl_bp = 0;
      sl_cnt = 0; sl_lag = 0;
      bus.bvalid = 0;
      bus.bresp = 0;
      bus.awready = 0;
      bus.wready = 0;
      return;
    end
    if (d_wv && !d_awv) saw_w_only = 1;
    if (d_awv && s_awr) begin
      sl_aw = 1;
      sl_lag = 0;
      wr_issued++;
    end
    if (d_wv && s_wr) begin
      sl_w = 1;
      wq.push_back(int'(d_wd));
    end
    if (s_bv && d_br) begin
      sl_bp = 0;
      b_count++;
    end
    if (sl_aw && sl_w && !sl_bp) begin
      sl_aw = 0;
      sl_w = 0;
      sl_bp = 1;
      sl_cnt = $urandom_range(bdel_max, bdel_min);
      sl_resp = (b_count + 1 == err_idx
                 || $urandom_range(99, 0) < err_pct)
                ? 2 : 0;
    end
    if (sl_aw && !sl_w) sl_lag++;
    bus.bvalid = sl_bp && (sl_cnt == 0);
    bus.bresp = bus.bvalid ? 2'(sl_resp) : 2'b00;
    if (sl_bp && sl_cnt > 0) sl_cnt--;
    if (w_lag > 0) begin
      bus.awready = 1;
      bus.wready = sl_aw && (sl_lag >= w_lag);
    end else begin
      bus.awready = $urandom_range(99, 0) < aw_pct;
      bus.wready = $urandom_range(99, 0) < w_pct;
    end
  endtask

  task automatic cycle();
    s_rst = rst_n; s_en = enable;
    s_clr = err_clr; s_mode = int'(mode);
    s_awr = bus.awready; s_wr = bus.wready;
    s_bv = bus.bvalid; s_bresp = int'(bus.bresp);
    d_awv = bus.awvalid; d_wv = bus.wvalid;
    d_br = bus.bready; d_wd = bus.wdata;
    @(negedge clk);
    model_step();
    compare();
    slave_drive();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_b(int n, int maxc);
    for (int i = 0; i < maxc && b_count < n; i++)
      cycle();
    chk("b_count_reached", b_count, n);
  endtask

  task automatic reset_checks();
    chk("rst_led", 32'(led_value), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_awvalid", 32'(bus.awvalid), 0);
    chk("rst_wvalid", 32'(bus.wvalid), 0);
    chk("rst_bready", 32'(bus.bready), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    enable = 0;
    err_clr = 0;
    #1;
    reset_checks();
    run(2);
    rst_n = 1;
    wr_issued = 0;
    b_count = 0;
    saw_w_only = 0;
    wq.delete();
  endtask

  task automatic zero_wait();
    aw_pct = 100; w_pct = 100; w_lag = 0;
    bdel_min = 0; bdel_max = 0;
    err_idx = -1; err_pct = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c[7] = '{1, 2, 4, 8, 1, 14, 1};
    bus.awready = 0; bus.wready = 0;
    bus.bvalid = 0; bus.bresp = 0;
    zero_wait();
    run(3);
    reset_checks();
    rst_n = 1;

    // mode 0 counting with a zero-wait slave
    mode = 0;
    enable = 1;
    run_until_b(5, 60);
    enable = 0;
    run(20);
    chk("m0_led", 32'(led_value), 5);
    chk("m0_err", 32'(err), 0);
    chk("m0_ovr", 32'(overrun), 0);
    chk("m0_writes", wr_issued, 5);
    chk("m0_nwq", wq.size(), 5);
    for (int i = 0; i < wq.size(); i++)
      chk("m0_data", wq[i], i + 1);

    // rotate then invert
    do_reset();
    mode = 1;
    enable = 1;
    run_until_b(5, 60);
    mode = 2;
    run_until_b(7, 30);
    enable = 0;
    run(4);
    chk("rot_nwq", wq.size(), 7);
    for (int i = 0; i < 7 && i < wq.size(); i++)
      chk("rot_data", wq[i], exp_c[i]);
    chk("rot_led", 32'(led_value), 1);

    // W channel lags AW
    do_reset();
    w_lag = 3;
    mode = 0;
    enable = 1;
    run_until_b(1, 40);
    enable = 0;
    run(10);
    chk("bp_writes", wr_issued, 1);
    chk("bp_bcount", b_count, 1);
    chk("bp_w_only", 32'(saw_w_only), 1);
    chk("bp_led", 32'(led_value), 1);
    zero_wait();

    // SLVERR on the third write
    do_reset();
    err_idx = 3;
    enable = 1;
    run_until_b(3, 50);
    chk("se_err", 32'(err), 1);
    chk("se_led", 32'(led_value), 2);
    run_until_b(4, 30);
    chk("se_retry", wq.size() > 3 ? wq[3] : -1, 3);
    chk("se_led4", 32'(led_value), 3);
    chk("se_sticky", 32'(err), 1);
    enable = 0;
    err_clr = 1;
    cycle();
    err_clr = 0;
    chk("se_clr", 32'(err), 0);
    zero_wait();

    // slow B response forces pending then overrun
    do_reset();
    bdel_min = 2 * P;
    bdel_max = 2 * P;
    enable = 1;
    run_until_b(1, 60);
    bdel_min = 0;
    bdel_max = 0;
    chk("ov_ovr", 32'(overrun), 1);
    run(5);
    chk("ov_writes", wr_issued, 2);
    chk("ov_bcount", b_count, 2);
    enable = 0;
    run(10);

    // enable drops while AW is still stalled
    do_reset();
    aw_pct = 0;
    enable = 1;
    for (int i = 0; i < 20 && !busy; i++) cycle();
    chk("xf_busy", 32'(busy), 1);
    enable = 0;
    run(3);
    aw_pct = 100;
    run_until_b(1, 20);
    run(20);
    chk("xf_writes", wr_issued, 1);
    chk("xf_idle", 32'(busy), 0);

    // reset while waiting for B
    do_reset();
    bdel_min = 10;
    bdel_max = 10;
    enable = 1;
    for (int i = 0; i < 30 && !bus.bready; i++)
      cycle();
    chk("rr_bready", 32'(bus.bready), 1);
    do_reset();
    run(20);
    chk("rr_writes", wr_issued, 0);
    zero_wait();

    // random traffic
    do_reset();
    aw_pct = 60;
    w_pct = 60;
    bdel_min = 0;
    bdel_max = 12;
    err_pct = 15;
    enable = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0)
        mode = 2'($urandom_range(3, 0));
      if ($urandom_range(99, 0) < 3)
        enable = ~enable;
      err_clr = $urandom_range(99, 0) < 4;
      if ($urandom_range(999, 0) < 2) begin
        do_reset();
        enable = 1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
